// File: rtl/row_window_reader_if.sv
// Bus bundle between the row window reader, the state BRAM read port and the
// parallel next-state array.
// Handshake: rd_en is a one-cycle read strobe and rd_data answers it exactly one
// cycle later with no backpressure; valid_set qualifies top/middle/bottom_row
// and calc_row_in for one cycle, and the consumer must accept it (no ready).
interface row_window_reader_if #(
  parameter int ROW_LENGTH = 1280
) ();
  logic                  rd_en;
  logic [9:0]            rd_addr;
  logic [ROW_LENGTH-1:0] rd_data;
  logic [ROW_LENGTH-1:0] top_row;
  logic [ROW_LENGTH-1:0] middle_row;
  logic [ROW_LENGTH-1:0] bottom_row;
  logic [9:0]            calc_row_in;
  logic                  valid_set;
  logic                  calc_flg;

  // Reader side: issues reads, receives data, produces windows.
  modport master (
    output rd_en, rd_addr, top_row, middle_row, bottom_row,
           calc_row_in, valid_set, calc_flg,
    input  rd_data
  );

  // BRAM / next-state side.
  modport slave (
    input  rd_en, rd_addr, top_row, middle_row, bottom_row,
           calc_row_in, valid_set, calc_flg,
    output rd_data
  );
endinterface

// File: rtl/row_window_reader.sv
// Streams one generation out of the read bank, one row per cycle, and keeps a
// sliding three-row window for the next-state array. Rows outside the grid
// read as zero: the window is cleared on start and a final flush shifts in 0.
module row_window_reader #(
  parameter int ROW_LENGTH = 1280,
  parameter int NUM_ROWS   = 720
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic               busy,
  output logic               done,
  output logic               bank_sel,
  output logic [1:0]         dbg_state,
  row_window_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] LAST_ROW = 10'(NUM_ROWS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [9:0]            rd_cnt;
  logic [9:0]            cap_cnt;
  logic                  rd_en_q;
  logic                  rd_fire;
  logic                  flush_fire;
  logic [ROW_LENGTH-1:0] top_q;
  logic [ROW_LENGTH-1:0] mid_q;
  logic [ROW_LENGTH-1:0] bot_q;
  logic [9:0]            row_q;
  logic                  valid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: FLUSH waits for the last read to land before the zero shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (!pause && rd_cnt == LAST_ROW) state_nxt = FLUSH;
      FLUSH:   if (!rd_en_q && !pause) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read strobe, flush strobe and activity flags.
  always_comb begin
    rd_fire    = 1'b0;
    flush_fire = 1'b0;
    busy       = 1'b0;
    case (state)
      READ:    begin rd_fire = !pause; busy = 1'b1; end
      FLUSH:   begin flush_fire = !rd_en_q && !pause; busy = 1'b1; end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  // Read counter and in-flight marker; counter doubles as the read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      rd_en_q <= rd_fire;
      if (state == IDLE && start) rd_cnt <= '0;
      else if (rd_fire)           rd_cnt <= rd_cnt + 10'd1;
    end
  end

  // Window shift on returning data or on the closing zero flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      cap_cnt <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state == IDLE && start) begin
        top_q   <= '0;
        mid_q   <= '0;
        bot_q   <= '0;
        cap_cnt <= '0;
      end else if (rd_en_q) begin
        top_q   <= mid_q;
        mid_q   <= bot_q;
        bot_q   <= bus.rd_data;
        cap_cnt <= cap_cnt + 10'd1;
        // Row 0 only primes the window; row k completes the window for k-1.
        if (cap_cnt != 10'd0) begin
          valid_q <= 1'b1;
          row_q   <= cap_cnt - 10'd1;
        end
      end else if (flush_fire) begin
        top_q   <= mid_q;
        mid_q   <= bot_q;
        bot_q   <= '0;
        valid_q <= 1'b1;
        row_q   <= LAST_ROW;
      end
    end
  end

  // End-of-generation pulse and bank swap, one cycle after the DONE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      bank_sel <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) bank_sel <= ~bank_sel;
    end
  end

  assign bus.rd_en       = rd_fire;
  assign bus.rd_addr     = rd_cnt;
  assign bus.top_row     = top_q;
  assign bus.middle_row  = mid_q;
  assign bus.bottom_row  = bot_q;
  assign bus.calc_row_in = row_q;
  assign bus.valid_set   = valid_q;
  assign bus.calc_flg    = busy;
  assign dbg_state       = state;

endmodule

// File: tb/tb_row_window_reader.sv
// Directed bench for row_window_reader with an 8-bit, 4-row grid.
module tb_row_window_reader;

  localparam int RL = 8;
  localparam int NR = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       busy;
  logic       done;
  logic       bank_sel;
  logic [1:0] dbg_state;

  row_window_reader_if #(.ROW_LENGTH(RL)) bus ();

  row_window_reader #(.ROW_LENGTH(RL), .NUM_ROWS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .busy      (busy),
    .done      (done),
    .bank_sel  (bank_sel),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // BRAM model: one-cycle read latency.
  logic [RL-1:0] mem [NR];
  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
  end
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[1:0]];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Emission record: {cycle[7:0], row[9:0], top, middle, bottom}
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  int          exp_done_q[$];
  int          got_done_q[$];
  logic [31:0] rd_mask;
  logic [31:0] zero_mask;
  logic        bank_hist [32];
  logic [9:0]  addr_hist [32];

  function automatic logic [41:0] em(input int c, input int r,
                                     input logic [7:0] t, input logic [7:0] m,
                                     input logic [7:0] b);
    return {8'(c), 10'(r), t, m, b};
  endfunction

  task automatic push_gen(input int c0, input int c1, input int c2, input int c3);
    exp_q.push_back(em(c0, 0, 8'h00, 8'h11, 8'h22));
    exp_q.push_back(em(c1, 1, 8'h11, 8'h22, 8'h33));
    exp_q.push_back(em(c2, 2, 8'h22, 8'h33, 8'h44));
    exp_q.push_back(em(c3, 3, 8'h33, 8'h44, 8'h00));
  endtask

  task automatic compare_runs(input string tag);
    chk({tag, "_em_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_em%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_done_count"}, 64'(got_done_q.size()), 64'(exp_done_q.size()));
    for (int i = 0; i < exp_done_q.size() && i < got_done_q.size(); i++)
      chk($sformatf("%s_done%0d", tag, i), 64'(got_done_q[i]), 64'(exp_done_q[i]));
    exp_q.delete();
    exp_done_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs n cycles from cycle 0 (start high in cycle 0 and in cycle s2),
  // pause per pmask bit, rst high in cycle rc; records what the DUT shows.
  task automatic run_gen(input logic [31:0] pmask, input int s2, input int rc, input int n);
    got_q.delete();
    got_done_q.delete();
    rd_mask   = '0;
    zero_mask = '0;
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == s2);
      pause = pmask[c];
      rst   = (c == rc);
      @(negedge clk);
      rd_mask[c]   = bus.rd_en;
      bank_hist[c] = bank_sel;
      addr_hist[c] = bus.rd_addr;
      zero_mask[c] = !bus.rd_en && bus.rd_addr == '0 && bus.top_row == '0 &&
                     bus.middle_row == '0 && bus.bottom_row == '0 &&
                     bus.calc_row_in == '0 && !bus.valid_set && !bus.calc_flg &&
                     !busy && !done && !bank_sel;
      if (bus.valid_set)
        got_q.push_back(em(c, int'(bus.calc_row_in), bus.top_row, bus.middle_row,
                           bus.bottom_row));
      if (done) got_done_q.push_back(c);
      @(posedge clk);
      #1;
    end
    start = 1'b0; pause = 1'b0; rst = 1'b0;
  endtask

  // ---------------- basic-generation vector table ----------------
  typedef struct {
    logic       start;
    logic       exp_rd_en;
    logic [9:0] exp_addr;
    logic       exp_valid;
    logic [9:0] exp_row;
    logic [7:0] exp_top;
    logic [7:0] exp_mid;
    logic [7:0] exp_bot;
    logic       exp_flg;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_bank;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(input logic s, input logic re, input int a, input logic v,
                              input int r, input logic [7:0] t, input logic [7:0] m,
                              input logic [7:0] b, input logic f, input logic bz,
                              input logic d, input logic bk);
    vec_t x;
    x.start = s; x.exp_rd_en = re; x.exp_addr = 10'(a); x.exp_valid = v;
    x.exp_row = 10'(r); x.exp_top = t; x.exp_mid = m; x.exp_bot = b;
    x.exp_flg = f; x.exp_busy = bz; x.exp_done = d; x.exp_bank = bk;
    return x;
  endfunction

  // ---------------- test ----------------
  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    //           st re adr v row  top    mid    bot   flg bsy dn bk
    vt[0] = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[1] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
    vt[2] = mk(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
    vt[3] = mk(0, 1, 2, 0, 0, 8'h00, 8'h00, 8'h11, 1, 1, 0, 0);
    vt[4] = mk(0, 1, 3, 1, 0, 8'h00, 8'h11, 8'h22, 1, 1, 0, 0);
    vt[5] = mk(0, 0, 0, 1, 1, 8'h11, 8'h22, 8'h33, 1, 1, 0, 0);
    vt[6] = mk(0, 0, 0, 1, 2, 8'h22, 8'h33, 8'h44, 1, 1, 0, 0);
    vt[7] = mk(0, 0, 0, 1, 3, 8'h33, 8'h44, 8'h00, 1, 1, 0, 0);
    vt[8] = mk(0, 0, 0, 0, 3, 8'h33, 8'h44, 8'h00, 0, 0, 1, 1);
    vt[9] = mk(0, 0, 0, 0, 3, 8'h33, 8'h44, 8'h00, 0, 0, 0, 1);

    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rst_addr", 64'(bus.rd_addr), 64'(0));
    chk("rst_valid", 64'(bus.valid_set), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_bank", 64'(bank_sel), 64'(0));
    chk("rst_window", 64'({bus.top_row, bus.middle_row, bus.bottom_row}), 64'(0));
    @(posedge clk);
    #1;

    // Basic generation, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      start = vt[i].start;
      pause = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d_rd_en", i), 64'(bus.rd_en), 64'(vt[i].exp_rd_en));
      if (vt[i].exp_rd_en)
        chk($sformatf("c%0d_addr", i), 64'(bus.rd_addr), 64'(vt[i].exp_addr));
      chk($sformatf("c%0d_valid", i), 64'(bus.valid_set), 64'(vt[i].exp_valid));
      chk($sformatf("c%0d_row", i), 64'(bus.calc_row_in), 64'(vt[i].exp_row));
      chk($sformatf("c%0d_top", i), 64'(bus.top_row), 64'(vt[i].exp_top));
      chk($sformatf("c%0d_mid", i), 64'(bus.middle_row), 64'(vt[i].exp_mid));
      chk($sformatf("c%0d_bot", i), 64'(bus.bottom_row), 64'(vt[i].exp_bot));
      chk($sformatf("c%0d_flg", i), 64'(bus.calc_flg), 64'(vt[i].exp_flg));
      chk($sformatf("c%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
      chk($sformatf("c%0d_done", i), 64'(done), 64'(vt[i].exp_done));
      chk($sformatf("c%0d_bank", i), 64'(bank_sel), 64'(vt[i].exp_bank));
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // Pause in cycles 2..3 during READ: everything slips by two cycles.
    run_gen(32'h0000_000C, -1, -1, 14);
    push_gen(6, 7, 8, 9);
    exp_done_q.push_back(10);
    compare_runs("pause_read");
    chk("pause_read_rd_mask", 64'(rd_mask[13:0]), 64'(14'h0072));
    chk("pause_read_addr_c2", 64'(addr_hist[2]), 64'(1));
    chk("pause_read_addr_c3", 64'(addr_hist[3]), 64'(1));
    chk("pause_read_bank_before", 64'(bank_hist[9]), 64'(1));
    chk("pause_read_bank_after", 64'(bank_hist[10]), 64'(0));

    // Pause in cycle 6 during FLUSH: only the last row and done slip.
    run_gen(32'h0000_0040, -1, -1, 12);
    push_gen(4, 5, 6, 8);
    exp_done_q.push_back(9);
    compare_runs("pause_flush");
    chk("pause_flush_bank", 64'(bank_hist[9]), 64'(1));

    // Second start while busy is ignored.
    run_gen(32'h0, 3, -1, 14);
    push_gen(4, 5, 6, 7);
    exp_done_q.push_back(8);
    compare_runs("start_busy");
    chk("start_busy_bank", 64'(bank_hist[8]), 64'(0));

    // Reset in cycle 5 abandons the generation.
    run_gen(32'h0, -1, 5, 12);
    exp_q.push_back(em(4, 0, 8'h00, 8'h11, 8'h22));
    exp_q.push_back(em(5, 1, 8'h11, 8'h22, 8'h33));
    compare_runs("rst_mid");
    chk("rst_mid_zero_c6_c11", 64'(zero_mask[11:6]), 64'(6'h3F));

    // Fresh start after reset reproduces the basic sequence.
    run_gen(32'h0, -1, -1, 10);
    push_gen(4, 5, 6, 7);
    exp_done_q.push_back(8);
    compare_runs("after_rst");
    chk("after_rst_bank_c7", 64'(bank_hist[7]), 64'(0));
    chk("after_rst_bank_c8", 64'(bank_hist[8]), 64'(1));

    // Back-to-back generations from bank 0.
    do_reset();
    run_gen(32'h0, 8, -1, 20);
    push_gen(4, 5, 6, 7);
    push_gen(12, 13, 14, 15);
    exp_done_q.push_back(8);
    exp_done_q.push_back(16);
    compare_runs("b2b");
    chk("b2b_bank_c8", 64'(bank_hist[8]), 64'(1));
    chk("b2b_bank_c15", 64'(bank_hist[15]), 64'(1));
    chk("b2b_bank_c16", 64'(bank_hist[16]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_window_reader.md
# row_window_reader

Front end of the next-state pipeline. Streams one generation of the grid out of the read bank of the double-buffered state BRAM, one row per cycle, and keeps a sliding three-row window. It presents each window to the parallel next-state array as `top_row`/`middle_row`/`bottom_row`, together with `calc_row_in`, `calc_flg` and `valid_set`. The next-state block turns these into a BRAM write of row `calc_row_in` into the write bank.

## Interface
- `row_length`, 1280: bits per grid row (cells per row).
- `num_rows`, 720: rows per generation; legal range 2..1024.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to process one generation; sampled only in IDLE.
- `pause`  in  1  when high, no new read or flush is issued that cycle.
- `rd_en`  out  1  BRAM read strobe.
- `rd_addr`  out  10  BRAM row address (read bank).
- `rd_data`  in  row_length  BRAM row; valid exactly 1 cycle after `rd_en`.
- `top_row`, `middle_row`, `bottom_row`  out  row_length each  window rows r-1, r, r+1.
- `calc_row_in`  out  10  row index r of the current window.
- `valid_set`  out  1  window outputs are valid this cycle.
- `calc_flg`  out  1  generation in progress.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse at generation end.
- `bank_sel`  out  1  current read bank; the write bank is `~bank_sel`.

## Operation
- States: IDLE, READ, FLUSH, DONE.
- **IDLE**
  - On `start`: clear all three window rows to 0, set read counter to 0, go to READ.
  - `start` in any other state is ignored.
- **READ**
  - Each cycle with `pause`=0: assert `rd_en`, drive `rd_addr` = counter, then increment the counter.
  - After issuing row `num_rows`-1, go to FLUSH.
  - With `pause`=1: `rd_en`=0 and `rd_addr` holds its value.
- **Capture** (any state)
  - A registered copy of `rd_en` marks returning data.
  - On returning data, shift the window: top<=middle, middle<=bottom, bottom<=`rd_data`.
  - Returning data is always captured, even while `pause` is high.
- **Emission**
  - A capture of row k, for k>=1, asserts `valid_set` with `calc_row_in` = k-1 on the same edge.
  - The capture of row 0 only primes the window and asserts nothing.
- **FLUSH**
  - Waits until no read is in flight and `pause`=0.
  - Then performs one shift with bottom<=0, asserts `valid_set` with `calc_row_in` = `num_rows`-1, and goes to DONE.
- **DONE**
  - For one cycle: `done`=1, `bank_sel` toggles, then go to IDLE.
- **Boundaries**
  - Rows above row 0 and below row `num_rows`-1 read as all-zero.
  - Columns are not padded here; the next-state array handles them.
- **Output behaviour**
  - `calc_flg` is 1 from the first READ cycle through the last `valid_set` cycle inclusive.
  - Window rows and `calc_row_in` hold their values when `valid_set`=0.
  - `valid_set` never asserts outside `calc_flg`.
- **Reset**
  - Every output resets to 0: `rd_en`, `rd_addr`, all window rows, `calc_row_in`, `valid_set`, `calc_flg`, `busy`, `done`, `bank_sel`.
  - State resets to IDLE.
  - Reset mid-generation abandons the generation and discards in-flight read data; no `valid_set` or `done` follows.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle k+1: row k is read (`rd_en` high).
- Cycle k+2: `rd_data` for row k is present and captured at the end of the cycle.
- Cycle k+3: the window holding rows k-2..k is visible; for k>=1, `valid_set` is high with `calc_row_in` = k-1.
- Without pause:
  - Row 0 is emitted in cycle 4.
  - Row `num_rows`-1 is emitted in cycle `num_rows`+3.
  - `done` pulses in cycle `num_rows`+4.
  - `bank_sel` takes its new value in cycle `num_rows`+4.
- Throughput: one row per cycle. Each paused cycle adds exactly one cycle to every later event.
- `valid_set` is a registered output. The downstream block registers `write_en`/`write_addr` one cycle later.

## Test plan
- **Basic generation** (`row_length`=8, `num_rows`=4, rows 0..3 = 0x11, 0x22, 0x33, 0x44), `start` at cycle 0:
  - Cycle 4: 00/11/22, row 0.
  - Cycle 5: 11/22/33, row 1.
  - Cycle 6: 22/33/44, row 2.
  - Cycle 7: 33/44/00, row 3.
  - `done` pulses in cycle 8; `bank_sel` = 1 from cycle 8; `calc_flg` high in cycles 1..7.
- **Pause mid-READ** (same setup, `pause` high in cycles 2..3):
  - `rd_en` low in cycles 2..3.
  - Row 0 data is still captured.
  - All emissions shift by 2: row 0 in cycle 6, `done` in cycle 10.
- **Pause during FLUSH** (`pause` high in cycle 6):
  - The row 3 emission moves from cycle 7 to cycle 8.
  - `done` moves to cycle 9.
- **Start while busy**: a second `start` at cycle 3 is ignored; exactly 4 `valid_set` pulses and one `done`.
- **Reset mid-generation**: `rst` at cycle 5.
  - From cycle 6 all outputs are 0 and `bank_sel` = 0.
  - There is no further `valid_set`.
  - A new `start` then reproduces the basic-generation sequence.
- **Back-to-back generations**: `start` in the first IDLE cycle after `done`.
  - The second generation has identical timing relative to its own `start`.
  - `bank_sel` returns to 0 after the second `done`.
